// File: rtl/ysyx_24100029_lsu_if.sv
// Single-outstanding request/response data bus between the LSU and memory.
// The LSU drives the master modport; the memory side uses slave.
interface ysyx_24100029_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_wen, req_addr,
      output req_wdata, req_wstrb, resp_ready,
      input  req_ready, resp_valid,
      input  resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr,
      input  req_wdata, req_wstrb, resp_ready,
      output req_ready, resp_valid,
      output resp_rdata, resp_err
   );
endinterface

// File: rtl/ysyx_24100029_lsu.sv
// Load/store stage: forwards the execute bundle to write-back and runs
// one data-bus transaction at a time for loads and stores.
module ysyx_24100029_lsu (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_last,
   output logic        ready_last,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [2:0]  funct3,
   input  logic [31:0] EX_result,
   input  logic [31:0] rs2_value,
   input  logic [4:0]  rd,
   input  logic        R_wen,
   input  logic [3:0]  csr_wen,
   ysyx_24100029_lsu_if.master bus,
   output logic        valid_next,
   input  logic        ready_next,
   output logic [31:0] wb_data,
   output logic [4:0]  rd_next,
   output logic        R_wen_next,
   output logic [3:0]  csr_wen_next,
   output logic        exc_misalign,
   output logic        exc_access
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        vn_q, vn_d;
   logic [31:0] wb_q, wb_d;
   logic [4:0]  rdn_q, rdn_d;
   logic        rwn_q, rwn_d;
   logic [3:0]  csrn_q, csrn_d;
   logic        mis_q, mis_d;
   logic        acc_q, acc_d;
   logic [4:0]  rd_q, rd_d;
   logic        rwen_q, rwen_d;
   logic [3:0]  csr_q, csr_d;
   logic [2:0]  f3_q, f3_d;
   logic        ld_q, ld_d;
   logic [31:0] ex_q, ex_d;

   logic        mem_op;
   logic        mis;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic [31:0] sh;
   logic [31:0] ld_val;
   logic        accept;

   assign mem_op = mem_ren | mem_wen;
   assign ready_last = (state_q == IDLE)
                    && (!vn_q || ready_next);
   assign accept = valid_last && ready_last;

   // funct3[1:0]: 00 byte, 01 half, anything else is a word
   always_comb begin
      mis     = 1'b0;
      st_strb = 4'hF;
      st_data = rs2_value;
      unique case (funct3[1:0])
         2'b00: begin
            st_strb = 4'b0001 << EX_result[1:0];
            st_data = {4{rs2_value[7:0]}};
         end
         2'b01: begin
            mis     = EX_result[0];
            st_strb = 4'b0011 << EX_result[1:0];
            st_data = {2{rs2_value[15:0]}};
         end
         default: mis = |EX_result[1:0];
      endcase
   end

   assign sh = bus.resp_rdata >> {ex_q[1:0], 3'b000};

   always_comb begin
      unique case (f3_q)
         3'b000:  ld_val = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ld_val = {24'd0, sh[7:0]};
         3'b001:  ld_val = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ld_val = {16'd0, sh[15:0]};
         default: ld_val = sh;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      vn_d    = vn_q;
      wb_d    = wb_q;
      rdn_d   = rdn_q;
      rwn_d   = rwn_q;
      csrn_d  = csrn_q;
      mis_d   = mis_q;
      acc_d   = acc_q;
      rd_d    = rd_q;
      rwen_d  = rwen_q;
      csr_d   = csr_q;
      f3_d    = f3_q;
      ld_d    = ld_q;
      ex_d    = ex_q;
      if (vn_q && ready_next) vn_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rd_d   = rd;
               rwen_d = R_wen;
               csr_d  = csr_wen;
               f3_d   = funct3;
               ld_d   = !mem_wen;
               ex_d   = EX_result;
               if (mem_op && !mis) begin
                  state_d = REQ;
                  wen_d   = mem_wen;
                  addr_d  = {EX_result[31:2], 2'b00};
                  wdata_d = mem_wen ? st_data : 32'd0;
                  wstrb_d = mem_wen ? st_strb : 4'd0;
               end else begin
                  vn_d   = 1'b1;
                  wb_d   = EX_result;
                  rdn_d  = rd;
                  rwn_d  = R_wen && !(mem_op && mis);
                  csrn_d = csr_wen;
                  mis_d  = mem_op && mis;
                  acc_d  = 1'b0;
               end
            end
         end
         REQ: begin
            if (bus.req_ready) state_d = RESP;
         end
         RESP: begin
            if (bus.resp_valid) begin
               state_d = IDLE;
               vn_d    = 1'b1;
               rdn_d   = rd_q;
               csrn_d  = csr_q;
               mis_d   = 1'b0;
               acc_d   = bus.resp_err;
               rwn_d   = rwen_q && !bus.resp_err;
               if (bus.resp_err) wb_d = 32'd0;
               else if (ld_q)    wb_d = ld_val;
               else              wb_d = ex_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wen_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         wstrb_q <= 4'd0;
         vn_q    <= 1'b0;
         wb_q    <= 32'd0;
         rdn_q   <= 5'd0;
         rwn_q   <= 1'b0;
         csrn_q  <= 4'd0;
         mis_q   <= 1'b0;
         acc_q   <= 1'b0;
         rd_q    <= 5'd0;
         rwen_q  <= 1'b0;
         csr_q   <= 4'd0;
         f3_q    <= 3'd0;
         ld_q    <= 1'b0;
         ex_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         vn_q    <= vn_d;
         wb_q    <= wb_d;
         rdn_q   <= rdn_d;
         rwn_q   <= rwn_d;
         csrn_q  <= csrn_d;
         mis_q   <= mis_d;
         acc_q   <= acc_d;
         rd_q    <= rd_d;
         rwen_q  <= rwen_d;
         csr_q   <= csr_d;
         f3_q    <= f3_d;
         ld_q    <= ld_d;
         ex_q    <= ex_d;
      end
   end

   assign bus.req_valid  = (state_q == REQ);
   assign bus.resp_ready = (state_q == RESP);
   assign bus.req_wen    = wen_q;
   assign bus.req_addr   = addr_q;
   assign bus.req_wdata  = wdata_q;
   assign bus.req_wstrb  = wstrb_q;

   assign valid_next   = vn_q;
   assign wb_data      = wb_q;
   assign rd_next      = rdn_q;
   assign R_wen_next   = rwn_q;
   assign csr_wen_next = csrn_q;
   assign exc_misalign = mis_q;
   assign exc_access   = acc_q;

endmodule

// File: tb/tb_ysyx_24100029_lsu.sv
// Directed bench for the load/store stage; the bench plays the data bus
// and write-back stage, with hand-computed expectations.
module tb_ysyx_24100029_lsu;
   logic        clock = 1'b0;
   logic        reset;
   logic        valid_last;
   logic        ready_last;
   logic        mem_ren;
   logic        mem_wen;
   logic [2:0]  funct3;
   logic [31:0] EX_result;
   logic [31:0] rs2_value;
   logic [4:0]  rd;
   logic        R_wen;
   logic [3:0]  csr_wen;
   logic        valid_next;
   logic        ready_next;
   logic [31:0] wb_data;
   logic [4:0]  rd_next;
   logic        R_wen_next;
   logic [3:0]  csr_wen_next;
   logic        exc_misalign;
   logic        exc_access;

   int total = 0;
   int bad = 0;

   ysyx_24100029_lsu_if bus ();

   ysyx_24100029_lsu dut (
      .clock        (clock),
      .reset        (reset),
      .valid_last   (valid_last),
      .ready_last   (ready_last),
      .mem_ren      (mem_ren),
      .mem_wen      (mem_wen),
      .funct3       (funct3),
      .EX_result    (EX_result),
      .rs2_value    (rs2_value),
      .rd           (rd),
      .R_wen        (R_wen),
      .csr_wen      (csr_wen),
      .bus          (bus),
      .valid_next   (valid_next),
      .ready_next   (ready_next),
      .wb_data      (wb_data),
      .rd_next      (rd_next),
      .R_wen_next   (R_wen_next),
      .csr_wen_next (csr_wen_next),
      .exc_misalign (exc_misalign),
      .exc_access   (exc_access)
   );

   always #5 clock = ~clock;

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // one load with the bus answering on the first possible cycles
   task automatic load1(input string tag,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] eaddr,
                        input logic [31:0] rdata,
                        input logic [31:0] exp);
      valid_last = 1'b1;
      mem_ren    = 1'b1;
      mem_wen    = 1'b0;
      funct3     = f3;
      EX_result  = addr;
      R_wen      = 1'b1;
      rd         = 5'd7;
      step();
      valid_last = 1'b0;
      mem_ren    = 1'b0;
      chk({tag, "_reqv"}, 32'(bus.req_valid), 32'd1);
      chk({tag, "_addr"}, bus.req_addr, eaddr);
      chk({tag, "_strb"}, 32'(bus.req_wstrb), 32'd0);
      chk({tag, "_rl"}, 32'(ready_last), 32'd0);
      chk({tag, "_vn0"}, 32'(valid_next), 32'd0);
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      chk({tag, "_reqv0"}, 32'(bus.req_valid), 32'd0);
      chk({tag, "_rspr"}, 32'(bus.resp_ready), 32'd1);
      bus.resp_valid = 1'b1;
      bus.resp_rdata = rdata;
      step();
      bus.resp_valid = 1'b0;
      chk({tag, "_vn"}, 32'(valid_next), 32'd1);
      chk({tag, "_wb"}, wb_data, exp);
      chk({tag, "_rw"}, 32'(R_wen_next), 32'd1);
      chk({tag, "_rd"}, 32'(rd_next), 32'd7);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      valid_last = 1'b0;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      funct3 = 3'd0;
      EX_result = 32'd0;
      rs2_value = 32'd0;
      rd = 5'd0;
      R_wen = 1'b0;
      csr_wen = 4'd0;
      ready_next = 1'b1;
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_rdata = 32'd0;
      bus.resp_err = 1'b0;

      repeat (2) step();
      chk("rst_vn", 32'(valid_next), 32'd0);
      chk("rst_reqv", 32'(bus.req_valid), 32'd0);
      chk("rst_wb", wb_data, 32'd0);
      chk("rst_strb", 32'(bus.req_wstrb), 32'd0);
      chk("rst_rdn", 32'(rd_next), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_rl", 32'(ready_last), 32'd1);
      bus.resp_valid = 1'b1;
      step();
      step();
      bus.resp_valid = 1'b0;
      chk("stray_vn", 32'(valid_next), 32'd0);

      // non-memory op and a 4-deep stream
      valid_last = 1'b1;
      EX_result = 32'h1234_5678;
      R_wen = 1'b1;
      rd = 5'd5;
      csr_wen = 4'h3;
      step();
      chk("nm_vn", 32'(valid_next), 32'd1);
      chk("nm_wb", wb_data, 32'h1234_5678);
      chk("nm_rd", 32'(rd_next), 32'd5);
      chk("nm_rw", 32'(R_wen_next), 32'd1);
      chk("nm_csr", 32'(csr_wen_next), 32'd3);
      for (int i = 0; i < 4; i++) begin
         EX_result = 32'hA000_0000 + 32'(i);
         rd = 5'(i + 1);
         chk("str_rl", 32'(ready_last), 32'd1);
         step();
         chk("str_vn", 32'(valid_next), 32'd1);
         chk("str_wb", wb_data, 32'hA000_0000 + 32'(i));
      end
      valid_last = 1'b0;
      csr_wen = 4'd0;
      step();
      chk("str_end", 32'(valid_next), 32'd0);

      load1("lb", 3'b000, 32'h8000_0003, 32'h8000_0000,
            32'h80FF_FF7F, 32'hFFFF_FF80);
      load1("lbu", 3'b100, 32'h8000_0003, 32'h8000_0000,
            32'h80FF_FF7F, 32'h0000_0080);
      load1("lh", 3'b001, 32'h8000_0002, 32'h8000_0000,
            32'h8001_0000, 32'hFFFF_8001);

      // store halfword with request backpressure
      valid_last = 1'b1;
      mem_wen = 1'b1;
      funct3 = 3'b001;
      EX_result = 32'h1000_0002;
      rs2_value = 32'hDEAD_BEEF;
      rd = 5'd9;
      R_wen = 1'b0;
      step();
      valid_last = 1'b0;
      mem_wen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sh_reqv", 32'(bus.req_valid), 32'd1);
         chk("sh_addr", bus.req_addr, 32'h1000_0000);
         chk("sh_strb", 32'(bus.req_wstrb), 32'hC);
         chk("sh_wdata", bus.req_wdata, 32'hBEEF_BEEF);
         chk("sh_wen", 32'(bus.req_wen), 32'd1);
         step();
      end
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      step();
      chk("sh_wait", 32'(valid_next), 32'd0);
      bus.resp_valid = 1'b1;
      step();
      bus.resp_valid = 1'b0;
      chk("sh_vn", 32'(valid_next), 32'd1);
      chk("sh_wb", wb_data, 32'h1000_0002);
      chk("sh_acc", 32'(exc_access), 32'd0);

      // misaligned word load
      valid_last = 1'b1;
      mem_ren = 1'b1;
      funct3 = 3'b010;
      EX_result = 32'h1000_0001;
      R_wen = 1'b1;
      rd = 5'd3;
      step();
      valid_last = 1'b0;
      mem_ren = 1'b0;
      chk("mis_reqv", 32'(bus.req_valid), 32'd0);
      chk("mis_vn", 32'(valid_next), 32'd1);
      chk("mis_exc", 32'(exc_misalign), 32'd1);
      chk("mis_rw", 32'(R_wen_next), 32'd0);

      // bus error with write-back backpressure
      valid_last = 1'b1;
      mem_ren = 1'b1;
      EX_result = 32'h2000_0000;
      rd = 5'd4;
      step();
      valid_last = 1'b0;
      mem_ren = 1'b0;
      ready_next = 1'b0;
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_err = 1'b1;
      bus.resp_rdata = 32'h1234_5678;
      step();
      bus.resp_valid = 1'b0;
      bus.resp_err = 1'b0;
      valid_last = 1'b1;
      EX_result = 32'hCAFE_0001;
      rd = 5'd2;
      for (int i = 0; i < 3; i++) begin
         chk("err_vn", 32'(valid_next), 32'd1);
         chk("err_acc", 32'(exc_access), 32'd1);
         chk("err_rw", 32'(R_wen_next), 32'd0);
         chk("err_wb", wb_data, 32'd0);
         chk("err_rl", 32'(ready_last), 32'd0);
         if (i < 2) step();
      end
      ready_next = 1'b1;
      #1;
      chk("bb_rl", 32'(ready_last), 32'd1);
      step();
      valid_last = 1'b0;
      chk("bb_wb", wb_data, 32'hCAFE_0001);
      chk("bb_acc", 32'(exc_access), 32'd0);
      chk("bb_rw", 32'(R_wen_next), 32'd1);
      step();
      chk("bb_end", 32'(valid_next), 32'd0);

      // reset in the middle of a response wait
      valid_last = 1'b1;
      mem_ren = 1'b1;
      EX_result = 32'h3000_0000;
      step();
      valid_last = 1'b0;
      mem_ren = 1'b0;
      bus.req_ready = 1'b1;
      step();
      bus.req_ready = 1'b0;
      chk("mr_rspr", 32'(bus.resp_ready), 32'd1);
      reset = 1'b1;
      #1;
      chk("mr_reqv", 32'(bus.req_valid), 32'd0);
      chk("mr_vn", 32'(valid_next), 32'd0);
      chk("mr_rspr0", 32'(bus.resp_ready), 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("mr_rl", 32'(ready_last), 32'd1);
      bus.resp_valid = 1'b1;
      step();
      step();
      bus.resp_valid = 1'b0;
      chk("mr_late_vn", 32'(valid_next), 32'd0);
      chk("mr_late_rq", 32'(bus.req_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_24100029_lsu.md
# ysyx_24100029_lsu

Load/store stage of the ysyx_24100029 five-stage pipeline. It sits between the execute stage and the write-back stage. It accepts the execute-stage bundle over a valid/ready handshake and forwards the bundle to write-back. For loads and stores it runs one transaction at a time on a single-outstanding request/response data bus. Loads are sign- or zero-extended per funct3. Misaligned and bus-error accesses are flagged.

## Interface
- No parameters; data/address width fixed at 32.
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- valid_last  in  1  execute-stage bundle valid.
- ready_last  out  1  stage can accept the bundle.
- mem_ren, mem_wen  in  1 each  load / store request; both set is treated as a store.
- funct3  in  3  RISC-V size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- EX_result  in  32  ALU result; this is the effective address for memory ops.
- rs2_value  in  32  store data.
- rd  in  5  destination register.
- R_wen  in  1  GPR write enable.
- csr_wen  in  4  CSR write enables, passed through.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_wen  out  1  1 = write.
- req_addr  out  32  word-aligned address ({EX_result[31:2],2'b00}).
- req_wdata  out  32  lane-replicated store data.
- req_wstrb  out  4  byte strobes; 0 for reads.
- resp_valid  in  1  bus response valid.
- resp_ready  out  1  stage accepts response.
- resp_rdata  in  32  read data.
- resp_err  in  1  bus error.
- valid_next  out  1  write-back bundle valid.
- ready_next  in  1  write-back ready.
- wb_data  out  32  load result, or EX_result for non-loads.
- rd_next  out  5  registered rd.
- R_wen_next  out  1  registered R_wen, gated by exceptions.
- csr_wen_next  out  4  registered csr_wen.
- exc_misalign  out  1  access was misaligned.
- exc_access  out  1  bus returned an error.

## Operation
- FSM states:
  - IDLE: accepts a new bundle.
  - REQ: req_valid asserted.
  - RESP: waiting for the response.
- Accept condition: ready_last = (state==IDLE) && (!valid_next || ready_next). A bundle is accepted when valid_last && ready_last. On accept, all inputs are captured.
- Non-memory bundle: stays in IDLE. valid_next=1 next cycle; wb_data=EX_result.
- Misaligned memory op (H/HU with addr[0]=1; W with addr[1:0]!=0):
  - No bus request is issued.
  - valid_next=1 next cycle with exc_misalign=1 and R_wen_next=0.
- Aligned memory op: IDLE→REQ.
  - REQ→RESP on req_valid && req_ready.
  - RESP→IDLE on resp_valid; valid_next=1 the following cycle.
- Stores also wait for the response before retiring.
- resp_ready = (state==RESP). resp_valid in IDLE or REQ is ignored.
- Store strobes:
  - SB: wstrb = 4'b0001<<a[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011<<a[1:0], wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'hF, wdata = rs2.
- Load extract: shift resp_rdata right by 8*a[1:0], then extend. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW uses the data unchanged.
- resp_err=1: exc_access=1, R_wen_next=0, wb_data=0.
- Output bundle registers hold while valid_next && !ready_next. valid_next clears on handshake unless a new bundle is captured in the same cycle.
- Undefined funct3 on a memory op is treated as W.

## Timing
- Reset (async) forces:
  - state = IDLE.
  - valid_next, req_valid, req_wen, resp_ready, exc_misalign, exc_access, R_wen_next = 0.
  - req_addr, req_wdata, req_wstrb, wb_data, rd_next, csr_wen_next = 0.
  - ready_last = 1 as soon as reset deasserts.
- Reset mid-transaction drops the transaction. A late resp_valid after reset is ignored because the FSM is in IDLE.
- Latency, accept edge → valid_next:
  - Non-memory op or misaligned op: 1 cycle.
  - Memory op: 3 cycles minimum, when req_ready and resp_valid each arrive on the first possible cycle. Each stall cycle adds 1.
- req_valid rises the cycle after accept. req_addr, req_wdata, req_wstrb and req_wen stay stable while req_valid && !req_ready.
- Throughput: 1 bundle per cycle for non-memory ops when ready_next=1. ready_last=0 during REQ and RESP.
- Back-to-back: a new bundle may be accepted in the same cycle the previous output handshakes.

## Test plan
- Reset check: assert reset mid-RESP → req_valid=0 and valid_next=0 immediately. After release, ready_last=1. A stray resp_valid is ignored, with no valid_next pulse.
- Non-memory op: EX_result=32'h1234_5678, R_wen=1, rd=5, ready_next=1 → valid_next next cycle, wb_data=32'h1234_5678, rd_next=5. A stream of 4 ops retires at 1 per cycle.
- Load LB at addr 32'h8000_0003, resp_rdata=32'h80FF_FF7F → req_addr=32'h8000_0000, req_wstrb=0, wb_data=32'hFFFF_FF80. With funct3=100 (LBU) → wb_data=32'h0000_0080. Also check LH at 0x2 on 32'h8001_0000 → wb_data=32'hFFFF_8001.
- Store SH at 32'h1000_0002, rs2=32'hDEAD_BEEF, req_ready held low for 3 cycles → req signals stable throughout, req_wstrb=4'b1100, req_wdata=32'hBEEF_BEEF. valid_next follows resp_valid by 1 cycle.
- Misaligned LW at 32'h1000_0001 → no req_valid, exc_misalign=1, R_wen_next=0 one cycle after accept.
- Error and backpressure: LW with resp_err=1 and ready_next=0 for 2 cycles → exc_access=1, R_wen_next=0, wb_data=0 held stable, ready_last=0 until the output handshake.
